// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder
//   Assembles 32-bit LEGv8 words (R/D/CB formats) from symbolic requests, queues them
//   in a small FIFO and presents them as a valid/ready stream to the fetch-side loader.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   CNT_W  width of the encoded-instruction counter
//
// Ports
//   clk_i           clock, all state on rising edge
//   rst_ni          asynchronous active-low reset
//   req_valid_i     request present
//   req_ready_o     request accepted when req_valid_i & req_ready_o
//   req_kind_i      0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 CBZ, 7 reserved
//   req_rd_i        Rd / Rt field
//   req_rn_i        Rn field
//   req_rm_i        Rm field (R-type only)
//   req_imm_i       signed immediate: D-type uses [8:0], CBZ uses [18:0]
//   instr_valid_o   instr_word_o valid
//   instr_ready_i   consumer takes word when instr_valid_o & instr_ready_i
//   instr_word_o    FIFO head word
//   enc_count_o     words pushed since reset, wraps
//   err_o           one-cycle pulse on a rejected request
//
// Build option
//   ILLEGAL_CHECK_EN  when defined, kind 7 and out-of-range D-type offsets are accepted,
//                     dropped and flagged on err_o. When undefined, err_o is tied low,
//                     kind 7 queues an all-zero word and D-type offsets are truncated.

module legv8_instr_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_kind_i,
    input  logic [4:0]       req_rd_i,
    input  logic [4:0]       req_rn_i,
    input  logic [4:0]       req_rm_i,
    input  logic [18:0]      req_imm_i,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic [31:0]      instr_word_o,
    output logic [CNT_W-1:0] enc_count_o,
    output logic             err_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      word_q, word_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] enc_word;
    logic        illegal;
    logic        full, empty, empty_next;
    logic        req_acc, push, pop;

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    always_comb begin
        enc_word = 32'h0000_0000;
        unique case (req_kind_i)
            3'd0: enc_word = {11'b10001011000, req_rm_i, 6'b000000, req_rn_i, req_rd_i};
            3'd1: enc_word = {11'b11001011000, req_rm_i, 6'b000000, req_rn_i, req_rd_i};
            3'd2: enc_word = {11'b10001010000, req_rm_i, 6'b000000, req_rn_i, req_rd_i};
            3'd3: enc_word = {11'b10101010000, req_rm_i, 6'b000000, req_rn_i, req_rd_i};
            3'd4: enc_word = {11'b11111000010, req_imm_i[8:0], 2'b00, req_rn_i, req_rd_i};
            3'd5: enc_word = {11'b11111000000, req_imm_i[8:0], 2'b00, req_rn_i, req_rd_i};
            3'd6: enc_word = {8'b10110100, req_imm_i, req_rd_i};
            3'd7: enc_word = 32'h0000_0000;
            default: enc_word = 32'h0000_0000;
        endcase
    end

`ifdef ILLEGAL_CHECK_EN
    logic imm_fits9;
    logic err_q;

    // Fits signed 9 bits when bits [18:8] are all copies of the sign bit.
    assign imm_fits9 = (&req_imm_i[18:8]) | ~(|req_imm_i[18:8]);
    assign illegal   = (req_kind_i == 3'd7) ||
                       (((req_kind_i == 3'd4) || (req_kind_i == 3'd5)) && !imm_fits9);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= req_acc & illegal;
        end
    end

    assign err_o = err_q;
`else
    assign illegal = 1'b0;
    assign err_o   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // No bypass: readiness depends only on registered occupancy.
    assign req_ready_o = !full;
    assign req_acc     = req_valid_i & !full;
    assign push        = req_acc & !illegal;
    assign pop         = instr_ready_i & !empty;

    assign wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
    assign rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
    assign empty_next = (wr_ptr_d == rd_ptr_d);
    assign cnt_d      = cnt_q + CNT_W'(push);

    // Output word register tracks the next head so the last head survives draining.
    always_comb begin
        word_d = word_q;
        if (!empty_next) begin
            if (push && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) begin
                word_d = enc_word;
            end else begin
                word_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= enc_word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            word_q   <= 32'h0000_0000;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            word_q   <= word_d;
            cnt_q    <= cnt_d;
        end
    end

    assign instr_valid_o = !empty;
    assign instr_word_o  = word_q;
    assign enc_count_o   = cnt_q;

endmodule

// File: tb/tb_legv8_instr_encoder.sv
module tb_legv8_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_kind;
    logic [4:0]  req_rd, req_rn, req_rm;
    logic [18:0] req_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic [15:0] enc_count;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [18:0] imm;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[10];

    legv8_instr_encoder #(
        .DEPTH(4),
        .CNT_W(16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_kind_i   (req_kind),
        .req_rd_i     (req_rd),
        .req_rn_i     (req_rn),
        .req_rm_i     (req_rm),
        .req_imm_i    (req_imm),
        .instr_valid_o(instr_valid),
        .instr_ready_i(instr_ready),
        .instr_word_o (instr_word),
        .enc_count_o  (enc_count),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [18:0] imm);
        req_valid = 1'b1;
        req_kind  = k;
        req_rd    = rd;
        req_rn    = rn;
        req_rm    = rm;
        req_imm   = imm;
    endtask

    initial begin
        vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  19'd0,      32'h8B03_0041};
        vecs[1] = '{3'd1, 5'd4,  5'd5,  5'd6,  19'd0,      32'hCB06_00A4};
        vecs[2] = '{3'd2, 5'd31, 5'd31, 5'd31, 19'd0,      32'h8A1F_03FF};
        vecs[3] = '{3'd3, 5'd0,  5'd1,  5'd2,  19'd0,      32'hAA02_0020};
        vecs[4] = '{3'd4, 5'd5,  5'd6,  5'd0,  19'd8,      32'hF840_80C5};
        vecs[5] = '{3'd5, 5'd5,  5'd6,  5'd0,  19'd8,      32'hF800_80C5};
        vecs[6] = '{3'd6, 5'd7,  5'd0,  5'd0,  19'h7FFFE,  32'hB4FF_FFC7};
        vecs[7] = '{3'd4, 5'd1,  5'd2,  5'd0,  19'h7FF00,  32'hF850_0041};
        vecs[8] = '{3'd5, 5'd3,  5'd4,  5'd0,  19'd255,    32'hF80F_F083};
        vecs[9] = '{3'd6, 5'd0,  5'd0,  5'd0,  19'h3FFFF,  32'hB47F_FFE0};

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_kind    = 3'd0;
        req_rd      = 5'd0;
        req_rn      = 5'd0;
        req_rm      = 5'd0;
        req_imm     = 19'd0;
        instr_ready = 1'b0;
        #12;
        chk("reset instr_valid", 32'(instr_valid), 32'd0);
        chk("reset instr_word",  instr_word, 32'h0);
        chk("reset req_ready",   32'(req_ready), 32'd1);
        chk("reset enc_count",   32'(enc_count), 32'd0);
        chk("reset err",         32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Table vectors, one at a time through an always-ready consumer.
        instr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].kind, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm);
            tick();
            req_valid = 1'b0;
            exp_cnt++;
            chk($sformatf("vec%0d valid", i), 32'(instr_valid), 32'd1);
            chk($sformatf("vec%0d word", i), instr_word, vecs[i].word);
            chk($sformatf("vec%0d count", i), 32'(enc_count), 32'(exp_cnt));
            chk($sformatf("vec%0d err", i), 32'(err), 32'd0);
            tick();
            chk($sformatf("vec%0d drained", i), 32'(instr_valid), 32'd0);
            chk($sformatf("vec%0d hold word", i), instr_word, vecs[i].word);
        end

        // Illegal / reserved requests.
`ifdef ILLEGAL_CHECK_EN
        drive(3'd7, 5'd1, 5'd2, 5'd3, 19'd0);
        tick();
        req_valid = 1'b0;
        chk("kind7 err", 32'(err), 32'd1);
        chk("kind7 not queued", 32'(instr_valid), 32'd0);
        chk("kind7 count", 32'(enc_count), 32'(exp_cnt));
        tick();
        chk("kind7 err pulse", 32'(err), 32'd0);
        drive(3'd4, 5'd1, 5'd2, 5'd0, 19'd300);
        tick();
        req_valid = 1'b0;
        chk("ldur300 err", 32'(err), 32'd1);
        chk("ldur300 not queued", 32'(instr_valid), 32'd0);
        chk("ldur300 count", 32'(enc_count), 32'(exp_cnt));
        tick();
        chk("ldur300 err pulse", 32'(err), 32'd0);
`else
        drive(3'd7, 5'd1, 5'd2, 5'd3, 19'd0);
        tick();
        req_valid = 1'b0;
        exp_cnt++;
        chk("kind7 queued", 32'(instr_valid), 32'd1);
        chk("kind7 word", instr_word, 32'h0000_0000);
        chk("kind7 count", 32'(enc_count), 32'(exp_cnt));
        chk("kind7 err", 32'(err), 32'd0);
        tick();
        drive(3'd4, 5'd1, 5'd2, 5'd0, 19'd300);
        tick();
        req_valid = 1'b0;
        exp_cnt++;
        chk("ldur300 truncated word", instr_word, 32'hF852_C041);
        chk("ldur300 count", 32'(enc_count), 32'(exp_cnt));
        chk("ldur300 err", 32'(err), 32'd0);
        tick();
`endif

        // Fill to DEPTH with a stalled consumer, then release.
        instr_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(3'd0, 5'(i), 5'd2, 5'd3, 19'd0);
            tick();
            exp_cnt++;
            chk($sformatf("fill%0d ready", i), 32'(req_ready), (i < 4) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d head", i), instr_word, 32'h8B03_0041);
        end
        drive(3'd0, 5'd5, 5'd2, 5'd3, 19'd0);
        tick();
        chk("full no push count", 32'(enc_count), 32'(exp_cnt));
        chk("full head stable", instr_word, 32'h8B03_0041);
        // Pop while full with a request pending: no push in the same cycle.
        instr_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("pop while full count", 32'(enc_count), 32'(exp_cnt));
        chk("ready after pop", 32'(req_ready), 32'd1);
        chk("order 2", instr_word, 32'h8B03_0042);
        tick();
        chk("order 3", instr_word, 32'h8B03_0043);
        tick();
        chk("order 4", instr_word, 32'h8B03_0044);
        chk("order 4 valid", 32'(instr_valid), 32'd1);
        tick();
        chk("fill drained", 32'(instr_valid), 32'd0);

        // Simultaneous push and pop keeps order.
        instr_ready = 1'b0;
        drive(3'd0, 5'd10, 5'd2, 5'd3, 19'd0);
        tick();
        instr_ready = 1'b1;
        drive(3'd0, 5'd11, 5'd2, 5'd3, 19'd0);
        chk("pp head A", instr_word, 32'h8B03_004A);
        tick();
        req_valid = 1'b0;
        exp_cnt += 2;
        chk("pp head B", instr_word, 32'h8B03_004B);
        chk("pp valid", 32'(instr_valid), 32'd1);
        chk("pp count", 32'(enc_count), 32'(exp_cnt));
        tick();
        chk("pp drained", 32'(instr_valid), 32'd0);

        // Asynchronous reset with words queued.
        instr_ready = 1'b0;
        drive(3'd0, 5'd12, 5'd2, 5'd3, 19'd0);
        tick();
        drive(3'd0, 5'd13, 5'd2, 5'd3, 19'd0);
        tick();
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("async rst valid", 32'(instr_valid), 32'd0);
        chk("async rst count", 32'(enc_count), 32'd0);
        chk("async rst word", instr_word, 32'h0);
        chk("async rst ready", 32'(req_ready), 32'd1);
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        chk("no stale words", 32'(instr_valid), 32'd0);
        instr_ready = 1'b1;
        drive(3'd0, 5'd9, 5'd2, 5'd3, 19'd0);
        tick();
        req_valid = 1'b0;
        exp_cnt++;
        chk("post rst word", instr_word, 32'h8B03_0049);
        chk("post rst count", 32'(enc_count), 32'(exp_cnt));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
